// File: rtl/splitter_tree_pkg.sv
// Shared types and helpers for the splitter_tree pulse fan-out block.
package splitter_tree_pkg;

   typedef enum logic {
      MODE_BCAST = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   localparam int unsigned MAX_OUT = 256;

   // Ceiling log2; gives the number of registered tree levels.
   function automatic int unsigned levels(input int unsigned n);
      int unsigned l;
      l = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) l = i + 1;
      end
      return l;
   endfunction

   // First enabled index after ptr, scanning upward with wrap; ptr itself is
   // reached last, so a lone enabled bit is always found. Returns ptr if none.
   function automatic int unsigned rr_next(input logic [MAX_OUT-1:0] mask,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned res;
      int unsigned idx;
      logic        found;
      res   = ptr;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_OUT; i++) begin
         if (!found && i <= n) begin
            idx = (ptr + i) & (n - 1);
            if (mask[idx]) begin
               found = 1'b1;
               res   = idx;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/splitter_tree_if.sv
// Pulse/control bundle for splitter_tree; counter signals exist only with
// SPLITTER_TREE_CNT_EN defined.
interface splitter_tree_if
   import splitter_tree_pkg::*;
#(
   parameter int unsigned N_OUT = 8
`ifdef SPLITTER_TREE_CNT_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
);

   localparam int unsigned LEVELS = levels(N_OUT);

   logic              in;
   logic              mode;
   logic              mask_wr;
   logic [N_OUT-1:0]  mask_in;
   logic [N_OUT-1:0]  out;
   logic [LEVELS-1:0] rr_ptr;
   logic              drop;
`ifdef SPLITTER_TREE_CNT_EN
   logic [LEVELS-1:0] cnt_sel;
   logic              cnt_clr;
   logic [CNT_W-1:0]  cnt_val;
`endif

   modport master (
      output in, mode, mask_wr, mask_in,
`ifdef SPLITTER_TREE_CNT_EN
      output cnt_sel, cnt_clr,
      input  cnt_val,
`endif
      input  out, rr_ptr, drop
   );

   modport slave (
      input  in, mode, mask_wr, mask_in,
`ifdef SPLITTER_TREE_CNT_EN
      input  cnt_sel, cnt_clr,
      output cnt_val,
`endif
      output out, rr_ptr, drop
   );

endinterface

// File: rtl/splitter_tree_node.sv
// One registered tree node: splits a parent pulse into two child pulses,
// each gated by whether its half of the carried destination vector is set.
module splitter_node #(
   parameter int unsigned W = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           par,
   input  logic [2*W-1:0] sub_d,
   output logic [1:0]     kid,
   output logic [2*W-1:0] kid_d
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kid   <= '0;
         kid_d <= '0;
      end else begin
         kid[0] <= par & (|sub_d[W-1:0]);
         kid[1] <= par & (|sub_d[2*W-1:W]);
         kid_d  <= sub_d;
      end
   end

endmodule

// File: rtl/splitter_tree.sv
// Registered binary fan-out tree with enable mask, broadcast/round-robin modes.
// Per-output pulse counters are built only with SPLITTER_TREE_CNT_EN defined.
module splitter_tree
   import splitter_tree_pkg::*;
#(
   parameter int unsigned N_OUT = 8,
   parameter int unsigned CNT_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   splitter_tree_if.slave bus
);

   localparam int unsigned LEVELS = levels(N_OUT);

   if (N_OUT < 2 || (N_OUT & (N_OUT - 1)) != 0 || N_OUT > MAX_OUT || CNT_W < 1)
   begin : g_cfg_check
      $error("splitter_tree: N_OUT must be a power of two in [2,MAX_OUT], CNT_W >= 1");
   end

   logic [N_OUT-1:0]  mask;
   logic [LEVELS-1:0] rr_ptr_q;
   logic [LEVELS-1:0] grant;
   logic              drop_q;
   logic [N_OUT-1:0]  dest;
   logic              mask_any;
   logic              mask_single;
   logic              rr_mode;
   logic [N_OUT-1:0]  leaf;

   always_comb begin
      mask_any    = |mask;
      mask_single = mask_any && ((mask & (mask - N_OUT'(1))) == '0);
      rr_mode     = (mode_e'(bus.mode) == MODE_RR);
      grant       = LEVELS'(rr_next(MAX_OUT'(mask), 32'(rr_ptr_q), N_OUT));
      dest        = '0;
      if (bus.in) begin
         if (rr_mode) begin
            if (mask_any) dest[grant] = 1'b1;
         end else begin
            dest = mask;
         end
      end
   end

   // The mask write lands after dest is formed, so a colliding pulse uses the old mask.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mask     <= '1;
         rr_ptr_q <= LEVELS'(N_OUT - 1);
         drop_q   <= 1'b0;
      end else begin
         if (bus.mask_wr) mask <= bus.mask_in;
         if (bus.in && rr_mode && mask_any && !mask_single) rr_ptr_q <= grant;
         drop_q <= bus.in && !mask_any;
      end
   end

   // Node pulses of all levels packed back to back: level k starts at 2^(k+1)-2.
   logic [2*N_OUT-3:0] node_p;
   logic [N_OUT-1:0]   node_d [LEVELS];

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int unsigned W  = N_OUT >> (k + 1);
      localparam int          PO = (1 << k) - 2;
      localparam int          CO = (2 << k) - 2;
      for (genvar j = 0; j < (1 << k); j++) begin : g_node
         logic           par;
         logic [2*W-1:0] pd;
         if (k == 0) begin : g_root
            assign par = bus.in;
            assign pd  = dest;
         end else begin : g_inner
            assign par = node_p[PO + j];
            assign pd  = node_d[k-1][j*2*W +: 2*W];
         end
         splitter_node #(.W(W)) u_node (
            .clk   (clk),
            .rst_n (rst_n),
            .par   (par),
            .sub_d (pd),
            .kid   (node_p[CO + 2*j +: 2]),
            .kid_d (node_d[k][j*2*W +: 2*W])
         );
      end
   end

   assign leaf       = node_p[N_OUT-2 +: N_OUT] & node_d[LEVELS-1];
   assign bus.out    = leaf;
   assign bus.rr_ptr = rr_ptr_q;
   assign bus.drop   = drop_q;

`ifdef SPLITTER_TREE_CNT_EN
   logic [CNT_W-1:0] cnt [N_OUT];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
         if (!rst_n) begin
            cnt[i] <= '0;
         end else if (bus.cnt_clr && bus.cnt_sel == LEVELS'(i)) begin
            cnt[i] <= '0;
         end else if (leaf[i] && cnt[i] != '1) begin
            cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   assign bus.cnt_val = cnt[bus.cnt_sel];
`endif

endmodule

// File: tb/tb_splitter_tree.sv
// Testbench for splitter_tree (N_OUT=8): directed vector table, randomized run
// against a reference model, and counter checks when SPLITTER_TREE_CNT_EN is set.
module tb_splitter_tree;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   splitter_tree_if #(
      .N_OUT(N)
`ifdef SPLITTER_TREE_CNT_EN
      , .CNT_W(2)
`endif
   ) bus ();

   splitter_tree #(.N_OUT(N), .CNT_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [7:0] m_mask;
   logic [7:0] m_out;
   logic [2:0] m_rr;
   logic       m_drop;
   logic [7:0] m_pipe [3];

   typedef struct {
      logic       r, i, m, w;
      logic [7:0] mi;
      logic [7:0] eo;
      logic       ed;
      logic [2:0] er;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(input logic r, i, m, w, input logic [7:0] mi,
                               input logic [7:0] eo, input logic ed, input logic [2:0] er);
      tbl.push_back('{r:r, i:i, m:m, w:w, mi:mi, eo:eo, ed:ed, er:er});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Destination: broadcast = mask; round robin = lowest enabled index above
   // the pointer, else lowest enabled overall; a single enabled bit keeps the pointer.
   task automatic model_step(input logic r, i, m, w, input logic [7:0] mi);
      logic [7:0] dv;
      int         g;
      if (!r) begin
         m_mask = 8'hFF;
         m_rr   = 3'd7;
         m_drop = 1'b0;
         m_out  = 8'h00;
         for (int k = 0; k < 3; k++) m_pipe[k] = 8'h00;
      end else begin
         dv = 8'h00;
         if (i && m_mask != 8'h00) begin
            if (!m) begin
               dv = m_mask;
            end else begin
               g = -1;
               for (int k = int'(m_rr) + 1; k < 8; k++) if (g < 0 && m_mask[k]) g = k;
               for (int k = 0; k <= int'(m_rr); k++) if (g < 0 && m_mask[k]) g = k;
               dv[g] = 1'b1;
               if ($countones(m_mask) != 1) m_rr = 3'(g);
            end
         end
         m_drop    = i && (m_mask == 8'h00);
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = dv;
         m_out     = m_pipe[2];
         if (w) m_mask = mi;
      end
   endtask

   task automatic step(input logic r, i, m, w, input logic [7:0] mi);
      rst_n       = r;
      bus.in      = i;
      bus.mode    = m;
      bus.mask_wr = w;
      bus.mask_in = mi;
      @(posedge clk);
      model_step(r, i, m, w, mi);
      #1;
   endtask

   initial begin
      logic       r, i, m, w, mode_r;
      logic [7:0] mi;

      rst_n       = 1'b0;
      bus.in      = 1'b0;
      bus.mode    = 1'b0;
      bus.mask_wr = 1'b0;
      bus.mask_in = 8'h00;
`ifdef SPLITTER_TREE_CNT_EN
      bus.cnt_sel = 3'd0;
      bus.cnt_clr = 1'b0;
`endif

      // reset, broadcast with default mask
      add(0,0,0,0,8'h00, 8'h00,0,7);
      add(0,0,0,0,8'h00, 8'h00,0,7);
      add(1,1,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'hFF,0,7);
      add(1,0,0,0,8'h00, 8'h00,0,7);
      // round robin, full mask, 10 back-to-back pulses
      for (int g = 0; g < 10; g++)
         add(1,1,1,0,8'h00, (g >= 2) ? 8'(1 << ((g - 2) % 8)) : 8'h00, 0, 3'(g % 8));
      add(1,0,1,0,8'h00, 8'h01,0,1);
      add(1,0,1,0,8'h00, 8'h02,0,1);
      // round robin, sparse mask 1001_0010 from reset pointer
      add(0,0,1,0,8'h00, 8'h00,0,7);
      add(1,0,1,1,8'h92, 8'h00,0,7);
      add(1,1,1,0,8'h00, 8'h00,0,1);
      add(1,1,1,0,8'h00, 8'h00,0,4);
      add(1,1,1,0,8'h00, 8'h02,0,7);
      add(1,1,1,0,8'h00, 8'h10,0,1);
      add(1,0,1,0,8'h00, 8'h80,0,1);
      add(1,0,1,0,8'h00, 8'h02,0,1);
      // empty mask, then write colliding with a pulse
      add(1,0,1,1,8'h00, 8'h00,0,1);
      add(1,1,1,0,8'h00, 8'h00,1,1);
      add(1,0,1,0,8'h00, 8'h00,0,1);
      add(1,1,1,1,8'h01, 8'h00,1,1);
      add(1,1,1,0,8'h00, 8'h00,0,1);
      add(1,0,1,0,8'h00, 8'h00,0,1);
      add(1,0,1,0,8'h00, 8'h01,0,1);
      add(1,0,1,0,8'h00, 8'h00,0,1);
      // broadcast mask write collision, then mode changes
      add(1,1,0,1,8'hA5, 8'h00,0,1);
      add(1,1,0,0,8'h00, 8'h00,0,1);
      add(1,0,0,0,8'h00, 8'h01,0,1);
      add(1,0,0,0,8'h00, 8'hA5,0,1);
      add(1,1,1,0,8'h00, 8'h00,0,2);
      add(1,1,0,0,8'h00, 8'h00,0,2);
      add(1,0,0,0,8'h00, 8'h04,0,2);
      add(1,0,0,0,8'h00, 8'hA5,0,2);
      // reset mid-flight
      add(1,1,0,0,8'h00, 8'h00,0,2);
      add(1,1,0,0,8'h00, 8'h00,0,2);
      add(0,1,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'h00,0,7);
      add(1,1,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'h00,0,7);
      add(1,0,0,0,8'h00, 8'hFF,0,7);

      for (int n = 0; n < tbl.size(); n++) begin
         step(tbl[n].r, tbl[n].i, tbl[n].m, tbl[n].w, tbl[n].mi);
         chk($sformatf("dir%0d.out", n),    32'(bus.out),    32'(tbl[n].eo));
         chk($sformatf("dir%0d.drop", n),   32'(bus.drop),   32'(tbl[n].ed));
         chk($sformatf("dir%0d.rr_ptr", n), 32'(bus.rr_ptr), 32'(tbl[n].er));
      end

      // randomized run against the model
      mode_r = 1'b0;
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(0, 59) != 0);
         i = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) mode_r = ~mode_r;
         m = mode_r;
         w = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 3))
            0:       mi = 8'h00;
            1:       mi = 8'(1 << $urandom_range(0, 7));
            2:       mi = 8'($urandom);
            default: mi = 8'hFF;
         endcase
         step(r, i, m, w, mi);
         chk($sformatf("rnd%0d.out", n),    32'(bus.out),    32'(m_out));
         chk($sformatf("rnd%0d.drop", n),   32'(bus.drop),   32'(m_drop));
         chk($sformatf("rnd%0d.rr_ptr", n), 32'(bus.rr_ptr), 32'(m_rr));
      end

`ifdef SPLITTER_TREE_CNT_EN
      // 2-bit counters: five broadcast pulses saturate at 3
      step(0,0,0,0,8'h00);
      for (int n = 0; n < 5; n++) step(1,1,0,0,8'h00);
      for (int n = 0; n < 3; n++) step(1,0,0,0,8'h00);
      bus.cnt_sel = 3'd3;
      #1;
      chk("cnt3.sat", 32'(bus.cnt_val), 32'd3);
      bus.cnt_sel = 3'd0;
      #1;
      chk("cnt0.sat", 32'(bus.cnt_val), 32'd3);
      // clear on the cycle out[3] pulses: clear wins
      bus.cnt_sel = 3'd3;
      step(1,1,0,0,8'h00);
      step(1,0,0,0,8'h00);
      step(1,0,0,0,8'h00);
      chk("cnt.pulse_at_out3", 32'(bus.out[3]), 32'd1);
      bus.cnt_clr = 1'b1;
      step(1,0,0,0,8'h00);
      bus.cnt_clr = 1'b0;
      chk("cnt3.clr_vs_inc", 32'(bus.cnt_val), 32'd0);
      step(1,0,0,0,8'h00);
      chk("cnt3.stays_clear", 32'(bus.cnt_val), 32'd0);
      bus.cnt_sel = 3'd5;
      #1;
      chk("cnt5.untouched", 32'(bus.cnt_val), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
